// File: rtl/phys_reg_free_list.sv
// ---------------------------------------------------------------------------
// phys_reg_free_list
//
// Circular FIFO of free physical-register tags feeding the rename stage.
// Head is where rename takes tags, tail is where the ROB returns them.
// Each pointer carries one extra msb so that a full list and an empty list
// can be told apart. Several checkpoint columns hold saved copies of head so
// that a mispredicted path can give back every tag it took with one restore.
//
// Ports
//   CLK                        single clock, rising edge
//   nRST                       asynchronous active-low reset
//   dequeue_valid              rename requests a free tag this cycle
//   dequeue_ready              list is non-empty
//   dequeue_phys_reg_tag       tag at head (combinational)
//   enqueue_valid              ROB returns a freed tag
//   enqueue_phys_reg_tag       tag to append at tail
//   save_checkpoint_valid      capture post-dequeue head into a column
//   save_checkpoint_column     column to write
//   restore_checkpoint_valid   roll head back to a column
//   restore_checkpoint_column  column to read
//   free_list_full             all FREE_LIST_DEPTH slots occupied
//   enqueue_overflow           sticky: an enqueue arrived while full
// ---------------------------------------------------------------------------
module phys_reg_free_list #(
  parameter int FREE_LIST_DEPTH       = 64,
  parameter int CHECKPOINT_COLUMNS    = 4,
  parameter int NUM_PHYS_REGS         = 64,
  parameter int NUM_ARCH_REGS         = 32,
  localparam int LOG_FREE_LIST_DEPTH  = $clog2(FREE_LIST_DEPTH),
  localparam int PTR_W                = LOG_FREE_LIST_DEPTH + 1,
  localparam int TAG_W                = $clog2(NUM_PHYS_REGS),
  localparam int COL_W                = (CHECKPOINT_COLUMNS > 1) ? $clog2(CHECKPOINT_COLUMNS) : 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             dequeue_valid,
  output logic             dequeue_ready,
  output logic [TAG_W-1:0] dequeue_phys_reg_tag,
  input  logic             enqueue_valid,
  input  logic [TAG_W-1:0] enqueue_phys_reg_tag,
  input  logic             save_checkpoint_valid,
  input  logic [COL_W-1:0] save_checkpoint_column,
  input  logic             restore_checkpoint_valid,
  input  logic [COL_W-1:0] restore_checkpoint_column,
  output logic             free_list_full,
  output logic             enqueue_overflow
);

  // Tags not bound to an architectural register at reset are the free ones.
  localparam int NUM_FREE_AT_RESET = NUM_PHYS_REGS - NUM_ARCH_REGS;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [TAG_W-1:0] tag_t;

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  logic overflow_q, overflow_d;
  tag_t entry_q  [FREE_LIST_DEPTH];
  ptr_t column_q [CHECKPOINT_COLUMNS];

  logic list_empty;
  logic list_full;
  logic dequeue_fire;
  logic enqueue_fire;
  logic save_fire;
  ptr_t head_after_dequeue;

  // Equal pointers mean empty; equal slot bits with opposite wrap bits mean full.
  assign list_empty = (head_q == tail_q);
  assign list_full  = (head_q[LOG_FREE_LIST_DEPTH-1:0] == tail_q[LOG_FREE_LIST_DEPTH-1:0]) &&
                      (head_q[LOG_FREE_LIST_DEPTH] != tail_q[LOG_FREE_LIST_DEPTH]);

  // A restore wins over a dequeue: the tag shown this cycle belongs to the
  // path being squashed, so it must not be consumed.
  assign dequeue_fire = dequeue_valid && !list_empty && !restore_checkpoint_valid;
  assign enqueue_fire = enqueue_valid && !list_full;
  assign save_fire    = save_checkpoint_valid && !restore_checkpoint_valid;

  // A saved checkpoint must already account for the tag taken in the same
  // cycle, otherwise a later restore would hand that tag out twice.
  assign head_after_dequeue = dequeue_fire ? (head_q + ptr_t'(1)) : head_q;

  always_comb begin
    head_d     = head_after_dequeue;
    tail_d     = tail_q;
    overflow_d = overflow_q;
    if (restore_checkpoint_valid) begin
      head_d = column_q[restore_checkpoint_column];
    end
    if (enqueue_fire) begin
      tail_d = tail_q + ptr_t'(1);
    end
    if (enqueue_valid && list_full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q     <= '0;
      tail_q     <= ptr_t'(NUM_FREE_AT_RESET);
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      overflow_q <= overflow_d;
    end
  end

  // Tag storage. Enqueued data is only readable from the next cycle; there is
  // deliberately no bypass from enqueue to the head output.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < FREE_LIST_DEPTH; i++) begin
        entry_q[i] <= (i < NUM_FREE_AT_RESET) ? tag_t'(i + NUM_ARCH_REGS) : '0;
      end
    end else if (enqueue_fire) begin
      entry_q[tail_q[LOG_FREE_LIST_DEPTH-1:0]] <= enqueue_phys_reg_tag;
    end
  end

  // Checkpoint columns: only a save (without a concurrent restore) writes them.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < CHECKPOINT_COLUMNS; i++) begin
        column_q[i] <= '0;
      end
    end else if (save_fire) begin
      column_q[save_checkpoint_column] <= head_after_dequeue;
    end
  end

  assign dequeue_ready        = !list_empty;
  assign dequeue_phys_reg_tag = entry_q[head_q[LOG_FREE_LIST_DEPTH-1:0]];
  assign free_list_full       = list_full;
  assign enqueue_overflow     = overflow_q;

endmodule
